// File: rtl/uart_boot_loader.sv
// UART boot loader: decodes W/R/G frames from the UART receive FIFO,
// performs 32-bit word transactions on the data bus, replies over the
// transmit FIFO, and releases the core from reset after a Go command.
`timescale 1ns/1ps
module uart_boot_loader #(
    parameter int unsigned TIMEOUT_CYCLES = 2000000,
    parameter logic [7:0]  ACK_BYTE       = 8'h06,
    parameter logic [7:0]  NAK_BYTE       = 8'h15
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        uart_rx_valid_i,
    input  logic [7:0]  uart_rx_rdata_i,
    output logic        uart_re_o,
    input  logic        uart_tx_full_i,
    output logic        uart_we_o,
    output logic [7:0]  uart_tx_wdata_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_ack_i,
    output logic        core_hold_o,
    output logic        boot_done_o,
    output logic        timeout_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_MEM,
        S_RESP,
        S_RESP4,
        S_GO
    } state_t;

    localparam logic [7:0]  CMD_W    = 8'h57;
    localparam logic [7:0]  CMD_R    = 8'h52;
    localparam logic [7:0]  CMD_G    = 8'h47;
    localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        is_wr_q, is_wr_d;
    logic        go_q, go_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic [7:0]  resp_q, resp_d;
    logic [31:0] tmo_q, tmo_d;
    logic        popped_q;

    logic        run;
    logic        counting;
    logic        pop;
    logic        push;
    logic        tmo_hit;
    logic [7:0]  tx_byte;

    // Next-state, receive pop, transmit push and timeout decisions
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        is_wr_d  = is_wr_q;
        go_d     = go_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        resp_d   = resp_q;
        push     = 1'b0;
        tx_byte  = 8'h00;

        run      = !rst_i;
        // The previous-cycle pop guard hides the FIFO's empty-flag lag.
        pop      = run && (state_q == S_IDLE || state_q == S_ADDR || state_q == S_DATA)
                   && uart_rx_valid_i && !popped_q;
        counting = (state_q == S_ADDR) || (state_q == S_DATA);
        tmo_hit  = run && counting && !pop && (tmo_q == TMO_LAST);
        tmo_d    = (counting && !pop) ? tmo_q + 32'd1 : 32'd0;

        unique case (state_q)
            S_IDLE: begin
                if (pop) begin
                    cnt_d = 2'd0;
                    go_d  = 1'b0;
                    if (uart_rx_rdata_i == CMD_W) begin
                        is_wr_d = 1'b1;
                        state_d = S_ADDR;
                    end else if (uart_rx_rdata_i == CMD_R) begin
                        is_wr_d = 1'b0;
                        state_d = S_ADDR;
                    end else if (uart_rx_rdata_i == CMD_G) begin
                        go_d    = 1'b1;
                        resp_d  = ACK_BYTE;
                        state_d = S_RESP;
                    end else begin
                        resp_d  = NAK_BYTE;
                        state_d = S_RESP;
                    end
                end
            end
            S_ADDR: begin
                if (pop) begin
                    addr_d[{cnt_q, 3'b000} +: 8] = uart_rx_rdata_i;
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        if (addr_d[1:0] != 2'b00) begin
                            resp_d  = NAK_BYTE;
                            state_d = S_RESP;
                        end else if (is_wr_q) begin
                            state_d = S_DATA;
                        end else begin
                            state_d = S_MEM;
                        end
                    end
                end else if (tmo_hit) begin
                    resp_d  = NAK_BYTE;
                    state_d = S_RESP;
                end
            end
            S_DATA: begin
                if (pop) begin
                    wdata_d[{cnt_q, 3'b000} +: 8] = uart_rx_rdata_i;
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        state_d = S_MEM;
                    end
                end else if (tmo_hit) begin
                    resp_d  = NAK_BYTE;
                    state_d = S_RESP;
                end
            end
            S_MEM: begin
                if (mem_ack_i) begin
                    if (is_wr_q) begin
                        resp_d  = ACK_BYTE;
                        state_d = S_RESP;
                    end else begin
                        rdata_d = mem_rdata_i;
                        cnt_d   = 2'd0;
                        state_d = S_RESP4;
                    end
                end
            end
            S_RESP: begin
                if (run && !uart_tx_full_i) begin
                    push    = 1'b1;
                    tx_byte = resp_q;
                    state_d = go_q ? S_GO : S_IDLE;
                end
            end
            S_RESP4: begin
                if (run && !uart_tx_full_i) begin
                    push    = 1'b1;
                    tx_byte = rdata_q[{cnt_q, 3'b000} +: 8];
                    cnt_d   = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_GO: begin
                state_d = S_GO;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers, all cleared by reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            cnt_q    <= 2'd0;
            is_wr_q  <= 1'b0;
            go_q     <= 1'b0;
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
            rdata_q  <= 32'd0;
            resp_q   <= 8'h00;
            tmo_q    <= 32'd0;
            popped_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            is_wr_q  <= is_wr_d;
            go_q     <= go_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            resp_q   <= resp_d;
            tmo_q    <= tmo_d;
            popped_q <= pop;
        end
    end

    assign uart_re_o       = pop;
    assign uart_we_o       = push;
    assign uart_tx_wdata_o = tx_byte;
    assign mem_req_o       = run && (state_q == S_MEM);
    assign mem_we_o        = is_wr_q;
    assign mem_addr_o      = addr_q;
    assign mem_wdata_o     = wdata_q;
    assign core_hold_o     = !run || (state_q != S_GO);
    assign boot_done_o     = run && (state_q == S_GO);
    assign timeout_o       = tmo_hit;

endmodule

// File: tb/tb_uart_boot_loader.sv
// Bench for uart_boot_loader: a byte-queue UART model, a memory responder
// and a frame-level reference model that predicts every reply byte and
// every bus transaction; one negedge process compares against the DUT.
`timescale 1ns/1ps
module tb_uart_boot_loader;

    localparam int TMO = 100;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        uart_rx_valid_i = 1'b0;
    logic [7:0]  uart_rx_rdata_i = 8'h00;
    logic        uart_re_o;
    logic        uart_tx_full_i = 1'b0;
    logic        uart_we_o;
    logic [7:0]  uart_tx_wdata_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i = 32'd0;
    logic        mem_ack_i = 1'b0;
    logic        core_hold_o;
    logic        boot_done_o;
    logic        timeout_o;

    uart_boot_loader #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk_i           (clk),
        .rst_i           (rst_i),
        .uart_rx_valid_i (uart_rx_valid_i),
        .uart_rx_rdata_i (uart_rx_rdata_i),
        .uart_re_o       (uart_re_o),
        .uart_tx_full_i  (uart_tx_full_i),
        .uart_we_o       (uart_we_o),
        .uart_tx_wdata_o (uart_tx_wdata_o),
        .mem_req_o       (mem_req_o),
        .mem_we_o        (mem_we_o),
        .mem_addr_o      (mem_addr_o),
        .mem_wdata_o     (mem_wdata_o),
        .mem_rdata_i     (mem_rdata_i),
        .mem_ack_i       (mem_ack_i),
        .core_hold_o     (core_hold_o),
        .boot_done_o     (boot_done_o),
        .timeout_o       (timeout_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } txn_t;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [7:0]  rxq[$];
    logic [7:0]  exp_tx[$];
    bit          exp_go[$];
    txn_t        exp_txn[$];
    logic [31:0] resp_mem[logic [31:0]];
    logic [31:0] model_mem[logic [31:0]];

    bit   hold_ack   = 1'b0;
    bit   full_force = 1'b0;
    bit   rand_full  = 1'b0;
    bit   go_now     = 1'b0;
    bit   tmo_armed  = 1'b0;
    int   tmo_seen   = 0;
    int   last_pop_cyc = 0;
    bit   pop_pending = 1'b0;
    int   ack_delay  = 0;
    logic prev_re    = 1'b0;
    logic prev_req   = 1'b0;
    txn_t req_snap;

    task automatic check(input string name, input logic [64:0] act, input logic [64:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic [31:0] dflt(input logic [31:0] a);
        return a ^ 32'h5A5A_A5A5;
    endfunction

    // Per-cycle UART/memory environment and output comparison
    always @(negedge clk) begin
        logic [31:0] rv;
        bit          g;
        txn_t        e;
        bit          go_next;
        cyc++;
        go_next = 1'b0;
        if (pop_pending && rxq.size() > 0) void'(rxq.pop_front());
        pop_pending = 1'b0;

        if (mem_ack_i) begin
            mem_ack_i = 1'b0;
        end else if (prev_req && !hold_ack) begin
            if (ack_delay > 0) begin
                ack_delay--;
            end else begin
                rv = resp_mem.exists(req_snap.addr) ? resp_mem[req_snap.addr] : dflt(req_snap.addr);
                mem_rdata_i = rv;
                mem_ack_i   = 1'b1;
            end
        end
        uart_rx_valid_i = (rxq.size() != 0);
        uart_rx_rdata_i = (rxq.size() != 0) ? rxq[0] : 8'h00;
        uart_tx_full_i  = full_force || (rand_full && ($urandom_range(0, 3) == 0));

        #1;
        if (rst_i) begin
            check("reset_hold", {core_hold_o, boot_done_o}, 2'b10);
            check("reset_quiet", {uart_re_o, uart_we_o, mem_req_o, timeout_o}, 4'b0000);
            prev_req = 1'b0;
            prev_re  = 1'b0;
        end else begin
            check("core_hold", {core_hold_o, boot_done_o}, {!go_now, go_now});
            if (go_now) check("quiet_in_go", {uart_re_o, uart_we_o, mem_req_o}, 3'b000);

            if (timeout_o) begin
                if (tmo_armed) check("tmo_latency", cyc - last_pop_cyc, TMO);
                else           check("tmo_unexpected", tmo_armed, 1'b1);
                tmo_armed = 1'b0;
                tmo_seen++;
            end

            if (uart_re_o) begin
                check("re_spacing", prev_re, 1'b0);
                check("re_with_data", rxq.size() != 0, 1'b1);
                pop_pending  = 1'b1;
                last_pop_cyc = cyc;
            end

            if (uart_we_o) begin
                check("we_while_full", uart_tx_full_i, 1'b0);
                if (exp_tx.size() == 0) begin
                    check("tx_unexpected", exp_tx.size(), 1);
                end else begin
                    check("tx_byte", uart_tx_wdata_o, exp_tx.pop_front());
                    g = exp_go.pop_front();
                    if (g) go_next = 1'b1;
                end
            end

            if (mem_req_o) begin
                if (!prev_req) begin
                    req_snap  = '{we: mem_we_o, addr: mem_addr_o, wdata: mem_wdata_o};
                    ack_delay = $urandom_range(0, 3);
                end else begin
                    check("req_stable", {mem_we_o, mem_addr_o, mem_wdata_o}, req_snap);
                end
                if (mem_ack_i) begin
                    if (exp_txn.size() == 0) begin
                        check("txn_unexpected", exp_txn.size(), 1);
                    end else begin
                        e = exp_txn.pop_front();
                        if (e.we) check("txn_write", {mem_we_o, mem_addr_o, mem_wdata_o}, e);
                        else      check("txn_read", {mem_we_o, mem_addr_o}, {e.we, e.addr});
                    end
                    if (mem_we_o) resp_mem[mem_addr_o] = mem_wdata_o;
                end
            end
            prev_re  = uart_re_o;
            prev_req = mem_req_o;
            if (go_next) go_now = 1'b1;
        end
    end

    task automatic expect_byte(input logic [7:0] b, input bit g);
        exp_tx.push_back(b);
        exp_go.push_back(g);
    endtask

    task automatic push_bytes(input logic [7:0] q[$]);
        foreach (q[i]) begin
            rxq.push_back(q[i]);
            repeat ($urandom_range(0, 4)) @(negedge clk);
        end
    endtask

    task automatic wait_done(input string name);
        bit done = 1'b0;
        for (int n = 0; n < 3000 && !done; n++) begin
            @(negedge clk);
            done = (rxq.size() == 0) && (exp_tx.size() == 0) && (exp_txn.size() == 0)
                   && !mem_ack_i && !mem_req_o;
        end
        check(name, done, 1'b1);
        repeat (2) @(negedge clk);
    endtask

    task automatic frame_write(input logic [31:0] a, input logic [31:0] d);
        logic [7:0] fb[$];
        fb.push_back(8'h57);
        for (int k = 0; k < 4; k++) fb.push_back(a[8*k +: 8]);
        for (int k = 0; k < 4; k++) fb.push_back(d[8*k +: 8]);
        exp_txn.push_back('{we: 1'b1, addr: a, wdata: d});
        expect_byte(8'h06, 1'b0);
        model_mem[a] = d;
        push_bytes(fb);
    endtask

    task automatic frame_read(input logic [31:0] a);
        logic [7:0]  fb[$];
        logic [31:0] v;
        v = model_mem.exists(a) ? model_mem[a] : dflt(a);
        fb.push_back(8'h52);
        for (int k = 0; k < 4; k++) fb.push_back(a[8*k +: 8]);
        exp_txn.push_back('{we: 1'b0, addr: a, wdata: 32'd0});
        for (int k = 0; k < 4; k++) expect_byte(v[8*k +: 8], 1'b0);
        push_bytes(fb);
    endtask

    task automatic frame_misaligned(input logic [7:0] cmd, input logic [31:0] a);
        logic [7:0] fb[$];
        fb.push_back(cmd);
        for (int k = 0; k < 4; k++) fb.push_back(a[8*k +: 8]);
        expect_byte(8'h15, 1'b0);
        push_bytes(fb);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_i = 1'b1;
        rxq.delete();
        exp_tx.delete();
        exp_go.delete();
        exp_txn.delete();
        tmo_armed = 1'b0;
        go_now    = 1'b0;
        @(negedge clk);
        rst_i = 1'b0;
    endtask

    initial begin
        logic [7:0]  q[$];
        logic [31:0] a;
        logic [7:0]  b;
        bit          seen;
        int          r;

        repeat (3) @(negedge clk);
        rst_i = 1'b0;
        @(negedge clk);
        #2;
        check("post_reset_state", {core_hold_o, boot_done_o, mem_req_o, uart_we_o}, 4'b1000);

        // Directed write with literal bytes and literal expectations
        exp_txn.push_back('{we: 1'b1, addr: 32'h0000_1000, wdata: 32'hDEAD_BEEF});
        expect_byte(8'h06, 1'b0);
        model_mem[32'h1000] = 32'hDEAD_BEEF;
        q = '{8'h57, 8'h00, 8'h10, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        push_bytes(q);
        wait_done("write_frame");

        // Directed read: LSB-first reply of a known word
        resp_mem[32'h1004]  = 32'h1234_5678;
        model_mem[32'h1004] = 32'h1234_5678;
        exp_txn.push_back('{we: 1'b0, addr: 32'h0000_1004, wdata: 32'd0});
        expect_byte(8'h78, 1'b0);
        expect_byte(8'h56, 1'b0);
        expect_byte(8'h34, 1'b0);
        expect_byte(8'h12, 1'b0);
        q = '{8'h52, 8'h04, 8'h10, 8'h00, 8'h00};
        push_bytes(q);
        wait_done("read_frame");

        // Unknown command and misaligned address
        expect_byte(8'h15, 1'b0);
        q = '{8'h41};
        push_bytes(q);
        wait_done("bad_cmd");
        expect_byte(8'h15, 1'b0);
        q = '{8'h57, 8'h01, 8'h10, 8'h00, 8'h00};
        push_bytes(q);
        wait_done("misaligned");
        frame_write(32'h0000_1008, 32'hCAFE_F00D);
        wait_done("write_after_nak");

        // Partial frame then silence
        expect_byte(8'h15, 1'b0);
        tmo_armed = 1'b1;
        tmo_seen  = 0;
        q = '{8'h57, 8'h00, 8'h10};
        push_bytes(q);
        wait_done("timeout_frame");
        check("timeout_pulses", tmo_seen, 1);
        frame_write(32'h0000_100C, 32'h0BAD_C0DE);
        wait_done("write_after_timeout");

        // Transmit backpressure during a read reply
        full_force = 1'b1;
        frame_read(32'h0000_2000);
        for (int n = 0; n < 500 && (exp_txn.size() != 0 || rxq.size() != 0); n++) @(negedge clk);
        repeat (50) @(negedge clk);
        check("stall_holds_reply", exp_tx.size(), 4);
        full_force = 1'b0;
        wait_done("stalled_read");

        // Randomised frames with random transmit-full pacing
        rand_full = 1'b1;
        for (int f = 0; f < 40; f++) begin
            r = $urandom_range(0, 8);
            a = 32'h8000_0000 | (32'($urandom_range(0, 15)) << 2);
            if (r <= 3) begin
                frame_write(a, $urandom);
            end else if (r <= 5) begin
                frame_read(a);
            end else if (r == 6) begin
                b = 8'($urandom_range(0, 255));
                while (b == 8'h57 || b == 8'h52 || b == 8'h47) b = 8'($urandom_range(0, 255));
                expect_byte(8'h15, 1'b0);
                q = '{b};
                push_bytes(q);
            end else begin
                frame_misaligned((r == 7) ? 8'h57 : 8'h52, a | 32'($urandom_range(1, 3)));
            end
            wait_done("random_frame");
        end
        rand_full = 1'b0;

        // Reset in the middle of a write frame
        q = '{8'h57, 8'h00, 8'h30, 8'h00, 8'h00, 8'h11};
        push_bytes(q);
        for (int n = 0; n < 200 && rxq.size() != 0; n++) @(negedge clk);
        do_reset();
        #2;
        check("reset_mid_frame", {core_hold_o, mem_req_o}, 2'b10);

        // Reset while a request is outstanding
        hold_ack = 1'b1;
        q = '{8'h57, 8'h00, 8'h30, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
        push_bytes(q);
        seen = 1'b0;
        for (int n = 0; n < 300 && !seen; n++) begin
            @(negedge clk);
            #2;
            seen = mem_req_o;
        end
        check("req_outstanding", seen, 1'b1);
        do_reset();
        hold_ack = 1'b0;
        #2;
        check("req_dropped", mem_req_o, 1'b0);
        frame_read(32'h0000_3000);
        wait_done("no_write_after_reset");

        // Go: ACK, release the core, stop touching the UART
        expect_byte(8'h06, 1'b1);
        q = '{8'h47};
        push_bytes(q);
        wait_done("go_frame");
        #2;
        check("go_released", {core_hold_o, boot_done_o}, 2'b01);
        q = '{8'h57, 8'h52, 8'h47};
        foreach (q[i]) rxq.push_back(q[i]);
        repeat (30) @(negedge clk);
        check("no_pop_after_go", rxq.size(), 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/uart_boot_loader.md
Name: uart_boot_loader

Overview:
- Serial-side responder that consumes bytes from the UART receive FIFO and returns replies through the UART transmit FIFO.
- Decodes a small command protocol (word write, word read, go) and issues 32-bit memory transactions on the core's data bus.
- Holds the core in reset until a Go command arrives, then releases it and leaves the UART entirely to the core.

Parameters:
TIMEOUT_CYCLES, 2000000, clk_i cycles allowed between bytes within one frame before the frame is aborted.
ACK_BYTE, 8'h06, reply byte for a successful write or go.
NAK_BYTE, 8'h15, reply byte for an unknown command, misaligned address or timeout.

Ports:
clk_i  in  1  system clock
rst_i  in  1  synchronous, active-high reset
uart_rx_valid_i  in  1  UART receive FIFO non-empty
uart_rx_rdata_i  in  8  receive FIFO head byte; valid while uart_rx_valid_i=1 (first-word-fall-through)
uart_re_o  out  1  pop receive FIFO, one-cycle pulse
uart_tx_full_i  in  1  UART transmit FIFO full
uart_we_o  out  1  push uart_tx_wdata_o into transmit FIFO, one-cycle pulse
uart_tx_wdata_o  out  8  transmit byte
mem_req_o  out  1  memory request, held until mem_ack_i
mem_we_o  out  1  1=write, 0=read; valid while mem_req_o=1
mem_addr_o  out  32  word-aligned byte address
mem_wdata_o  out  32  write data
mem_rdata_i  in  32  read data, sampled on mem_ack_i
mem_ack_i  in  1  one-cycle transaction completion
core_hold_o  out  1  holds the core in reset while 1
boot_done_o  out  1  Go command accepted
timeout_o  out  1  one-cycle pulse when a frame is aborted on timeout

Behaviour:
- Single clock domain. On rst_i=1 all state is synchronously cleared: state=IDLE, outputs 0 except core_hold_o=1. Reset mid-frame or mid-transaction discards everything in progress, including a request that has not yet been acknowledged.
- Frame formats. All multi-byte fields are little-endian.
  - 'W' (8'h57): 4 address bytes, then 4 data bytes.
  - 'R' (8'h52): 4 address bytes.
  - 'G' (8'h47): no payload.
- Receive pop rule:
  - uart_re_o=1 for one cycle only when the state expects a byte, uart_rx_valid_i=1, and there was no pop in the previous cycle. At most one pop every 2 cycles, to cover empty-flag lag.
  - The byte is captured in the same cycle as the pop.
- State machine:
  - IDLE: pops a byte. 'W'/'R' -> ADDR with byte counter=0; 'G' -> RESP(ACK) and then GO; any other byte -> RESP(NAK).
  - ADDR: pops 4 bytes into addr[8k+7:8k]. After the 4th byte:
    - addr[1:0]!=0 -> RESP(NAK);
    - 'W' -> DATA;
    - 'R' -> MEM.
  - DATA: pops 4 bytes into wdata, then -> MEM.
  - MEM: asserts mem_req_o in the cycle after the last byte pop. Holds addr, we and wdata stable until mem_ack_i.
    - Write: on ack -> RESP(ACK).
    - Read: on ack, rdata is captured -> RESP4 (4 bytes, LSB first).
  - RESP / RESP4: drives uart_we_o=1 for one cycle per byte, only when uart_tx_full_i=0. Full stalls without losing a byte. Returns to IDLE after the last byte, or to GO for a Go command.
  - GO: core_hold_o=0 and boot_done_o=1 until reset. uart_re_o and uart_we_o are permanently 0. mem_req_o=0.
- Timeout:
  - In ADDR or DATA, a 32-bit counter counts cycles since the last pop.
  - At TIMEOUT_CYCLES: timeout_o pulses, partial frame discarded, -> RESP(NAK).
  - Timeout is not active in IDLE, MEM or RESP.
- Latency from the final payload pop to mem_req_o rising: 1 cycle. From mem_ack_i to the first uart_we_o: 1 cycle when the transmit FIFO is not full.
- The byte counter wraps from 3 back to 0 on each field change. Only one frame is in flight at a time. Bytes that arrive during MEM or RESP stay queued in the UART FIFO.

Test Plan:
- Write: 57 00 10 00 00 EF BE AD DE -> one mem_req_o with we=1, addr=32'h00001000, wdata=32'hDEADBEEF. After ack, a single uart_we_o with byte 06.
- Read: 52 04 10 00 00, mem_rdata_i=32'h12345678 on ack -> uart bytes 78 56 34 12 in order, then IDLE.
- Error frames:
  - Byte 41 -> single byte 15.
  - 57 01 10 00 00 (misaligned) -> byte 15, no mem_req_o. A following valid 'W' frame completes normally.
- Timeout: 57 00 10, then silence, TIMEOUT_CYCLES=100 -> timeout_o pulses exactly 100 cycles after the last pop, byte 15 sent. The next 'W' frame is decoded correctly.
- Backpressure and pacing:
  - Read with uart_tx_full_i=1 for 50 cycles -> no uart_we_o during the stall; all 4 bytes delivered in order once full drops.
  - uart_re_o never asserts in consecutive cycles.
- Go and reset:
  - 47 -> byte 06, then core_hold_o 1->0 and boot_done_o=1. Later rx bytes are never popped.
  - rst_i mid-'W' frame -> core_hold_o=1, state IDLE, no memory write.
